// File: rtl/nvram_pkg.sv
// Shared types and defaults for the NVRAM upload responder.
package nvram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PAUSE  = 3'd1,
        ST_READY  = 3'd2,
        ST_FETCH  = 3'd3,
        ST_LAT    = 3'd4,
        ST_FINISH = 3'd5
    } upl_state_t;

    localparam logic [7:0] UPL_INDEX_DEF = 8'd4;
    localparam logic [7:0] FILL_DEF      = 8'hFF;

endpackage

// File: rtl/lat_pipe.sv
// RD_LAT-deep valid shift register: strike marks the cycle mem_q is valid.
module lat_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic start,
    output logic strike
);

    logic [RD_LAT-1:0] vld_r;

    // Shift the read-issued marker down the latency chain.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            vld_r <= '0;
        end else begin
            vld_r[0] <= start;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_r[i] <= vld_r[i-1];
            end
        end
    end

    assign strike = vld_r[RD_LAT-1];

endmodule

// File: rtl/nvram_upload_ctl.sv
// Serves hps_io upload read strobes from save RAM while the CPU is paused,
// and tracks whether save RAM changed since the last complete upload.
module nvram_upload_ctl
    import nvram_pkg::*;
#(
    parameter int         AW        = 11,
    parameter int         DEPTH     = 2048,
    parameter logic [7:0] UPL_INDEX = UPL_INDEX_DEF,
    parameter int         RD_LAT    = 1,
    parameter logic [7:0] FILL      = FILL_DEF
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          pause_req,
    input  logic          pause_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_q,
    input  logic          cpu_we,
    output logic          save_dirty,
    output logic          upl_busy
);

    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic [24:0]    DEPTH_A = 25'(DEPTH);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    upl_state_t     state_r, state_nxt_s;
    logic           sel_s, sel_r, rise_s, strike_s, fin_clr_s;
    logic           wait_r, wait_nxt_s, pend_r, pend_nxt_s, sess_we_r;
    logic           pause_nxt_s, busy_nxt_s, mem_rd_nxt_s;
    logic [7:0]     din_nxt_s;
    logic [AW-1:0]  mem_addr_nxt_s;
    logic [24:0]    addr_r, addr_nxt_s, req_addr_s;
    logic [CW-1:0]  cnt_r, cnt_nxt_s;

    assign sel_s      = ioctl_upload && (ioctl_index == UPL_INDEX);
    assign rise_s     = sel_s && !sel_r;
    assign req_addr_s = ioctl_rd ? ioctl_addr : addr_r;
    assign ioctl_wait = wait_r | ((state_r == ST_READY) & sel_s & ioctl_rd);
    assign fin_clr_s  = (state_r == ST_FINISH) && (cnt_r == DEPTH_C) && !sess_we_r;

    lat_pipe #(.RD_LAT(RD_LAT)) u_lat_pipe (
        .clk_sys (clk_sys),
        .reset   (reset),
        .start   (mem_rd),
        .strike  (strike_s)
    );

    // Next-state and next-output decode; mem_rd is issued on entry to FETCH.
    always_comb begin
        state_nxt_s    = state_r;
        pause_nxt_s    = pause_req;
        busy_nxt_s     = upl_busy;
        wait_nxt_s     = wait_r;
        din_nxt_s      = ioctl_din;
        mem_rd_nxt_s   = 1'b0;
        mem_addr_nxt_s = mem_addr;
        addr_nxt_s     = addr_r;
        pend_nxt_s     = pend_r;
        cnt_nxt_s      = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_nxt_s = ST_PAUSE;
                    pause_nxt_s = 1'b1;
                    busy_nxt_s  = 1'b1;
                    wait_nxt_s  = 1'b1;
                    pend_nxt_s  = 1'b0;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PAUSE: begin
                if (ioctl_rd) begin
                    addr_nxt_s = ioctl_addr;
                    pend_nxt_s = 1'b1;
                end else begin
                    addr_nxt_s = addr_r;
                end
                if (!sel_s) begin
                    state_nxt_s = ST_FINISH;
                    pause_nxt_s = 1'b0;
                    busy_nxt_s  = 1'b0;
                    wait_nxt_s  = 1'b0;
                    pend_nxt_s  = 1'b0;
                end else if (pause_ack) begin
                    if (pend_r || ioctl_rd) begin
                        state_nxt_s    = ST_FETCH;
                        pend_nxt_s     = 1'b0;
                        mem_addr_nxt_s = req_addr_s[AW-1:0];
                        mem_rd_nxt_s   = (req_addr_s < DEPTH_A);
                    end else begin
                        state_nxt_s = ST_READY;
                        wait_nxt_s  = 1'b0;
                    end
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            ST_READY: begin
                if (!sel_s) begin
                    state_nxt_s = ST_FINISH;
                    pause_nxt_s = 1'b0;
                    busy_nxt_s  = 1'b0;
                    wait_nxt_s  = 1'b0;
                end else if (ioctl_rd) begin
                    state_nxt_s    = ST_FETCH;
                    wait_nxt_s     = 1'b1;
                    addr_nxt_s     = ioctl_addr;
                    mem_addr_nxt_s = ioctl_addr[AW-1:0];
                    mem_rd_nxt_s   = (ioctl_addr < DEPTH_A);
                end else begin
                    state_nxt_s = ST_READY;
                end
            end
            ST_FETCH: begin
                if (addr_r < DEPTH_A) begin
                    state_nxt_s = ST_LAT;
                end else begin
                    state_nxt_s = ST_READY;
                    din_nxt_s   = FILL;
                    wait_nxt_s  = 1'b0;
                end
            end
            ST_LAT: begin
                if (strike_s) begin
                    state_nxt_s = ST_READY;
                    din_nxt_s   = mem_q;
                    wait_nxt_s  = 1'b0;
                    cnt_nxt_s   = (cnt_r == DEPTH_C) ? cnt_r : cnt_r + CW'(1);
                end else begin
                    state_nxt_s = ST_LAT;
                end
            end
            ST_FINISH: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                pause_nxt_s = 1'b0;
                busy_nxt_s  = 1'b0;
                wait_nxt_s  = 1'b0;
            end
        endcase
    end

    // FSM state, registered outputs and transaction bookkeeping.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            sel_r     <= 1'b0;
            wait_r    <= 1'b0;
            pend_r    <= 1'b0;
            addr_r    <= '0;
            cnt_r     <= '0;
            pause_req <= 1'b0;
            upl_busy  <= 1'b0;
            ioctl_din <= 8'h00;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
        end else begin
            state_r   <= state_nxt_s;
            sel_r     <= sel_s;
            wait_r    <= wait_nxt_s;
            pend_r    <= pend_nxt_s;
            addr_r    <= addr_nxt_s;
            cnt_r     <= cnt_nxt_s;
            pause_req <= pause_nxt_s;
            upl_busy  <= busy_nxt_s;
            ioctl_din <= din_nxt_s;
            mem_rd    <= mem_rd_nxt_s;
            mem_addr  <= mem_addr_nxt_s;
        end
    end

    // Remember any CPU write seen while a session is open.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sess_we_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && rise_s) begin
            sess_we_r <= 1'b0;
        end else if (cpu_we && (state_r != ST_IDLE)) begin
            sess_we_r <= 1'b1;
        end else begin
            sess_we_r <= sess_we_r;
        end
    end

    // Dirty flag: a write always wins over the end-of-upload clear.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            save_dirty <= 1'b0;
        end else if (cpu_we) begin
            save_dirty <= 1'b1;
        end else if (fin_clr_s) begin
            save_dirty <= 1'b0;
        end else begin
            save_dirty <= save_dirty;
        end
    end

endmodule

// File: tb/tb_nvram_upload_ctl.sv
// Directed sessions with randomized RAM contents and addresses, checked
// against a behavioural model of the upload and dirty-flag rules.
module tb_nvram_upload_ctl;

    localparam int         AW     = 11;
    localparam int         DEPTH  = 2048;
    localparam int         RD_LAT = 2;
    localparam logic [7:0] FILL   = 8'hFF;

    logic          clk_sys = 1'b0;
    logic          reset, ioctl_upload, ioctl_rd, pause_ack, cpu_we;
    logic [7:0]    ioctl_index, ioctl_din, mem_q;
    logic [24:0]   ioctl_addr;
    logic          ioctl_wait, pause_req, mem_rd, save_dirty, upl_busy;
    logic [AW-1:0] mem_addr;

    nvram_upload_ctl #(.AW(AW), .DEPTH(DEPTH), .UPL_INDEX(8'd4), .RD_LAT(RD_LAT), .FILL(FILL)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
        .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .pause_req(pause_req), .pause_ack(pause_ack), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_q(mem_q), .cpu_we(cpu_we), .save_dirty(save_dirty), .upl_busy(upl_busy)
    );

    always #5 clk_sys = ~clk_sys;

    // RAM model with RD_LAT=2 registered read; non-read cycles return 0.
    logic [7:0] ram [0:DEPTH-1];
    logic [7:0] q1 = 8'h00, q2 = 8'h00;
    always @(posedge clk_sys) begin
        q1 <= mem_rd ? ram[mem_addr] : 8'h00;
        q2 <= q1;
    end
    assign mem_q = q2;

    // Monitors sampled on the falling edge.
    int mem_rd_cnt = 0, pause_cnt = 0, wait_cnt = 0;
    logic [AW-1:0] last_mem_addr = '0;
    always @(negedge clk_sys) begin
        if (mem_rd) begin
            mem_rd_cnt    <= mem_rd_cnt + 1;
            last_mem_addr <= mem_addr;
        end
        if (pause_req)  pause_cnt <= pause_cnt + 1;
        if (ioctl_wait) wait_cnt  <= wait_cnt + 1;
    end

    int checks = 0, errors = 0;
    int bytes_read = 0;
    bit exp_dirty = 1'b0, sess_we = 1'b0, in_sess = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_din"},   ioctl_din,  8'h00);
        check({tag, "_wait"},  ioctl_wait, 1'b0);
        check({tag, "_pause"}, pause_req,  1'b0);
        check({tag, "_busy"},  upl_busy,   1'b0);
        check({tag, "_mrd"},   mem_rd,     1'b0);
        check({tag, "_maddr"}, mem_addr,   '0);
        check({tag, "_dirty"}, save_dirty, 1'b0);
    endtask

    // One strobe from READY; expectations follow the address rules.
    task automatic do_read(input logic [24:0] a);
        int n, rd0;
        logic [7:0] exp;
        bit in_rng;
        in_rng = (a < 25'(DEPTH));
        exp = in_rng ? ram[a[AW-1:0]] : FILL;
        rd0 = mem_rd_cnt;
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        #1;
        check("wait_comb", ioctl_wait, 1'b1);
        tick();
        ioctl_rd = 1'b0;
        n = 1;
        while (ioctl_wait && n < 20) begin
            tick();
            n++;
        end
        check("latency", n, in_rng ? RD_LAT + 2 : 2);
        check("din", ioctl_din, exp);
        check("mem_rd_pulses", mem_rd_cnt - rd0, in_rng ? 1 : 0);
        if (in_rng) begin
            check("mem_addr", last_mem_addr, a[AW-1:0]);
            bytes_read++;
        end
    endtask

    task automatic start_session();
        int n;
        ioctl_index  = 8'd4;
        ioctl_upload = 1'b1;
        sess_we = 1'b0; bytes_read = 0; in_sess = 1'b1;
        tick();
        check("pause_req_on", pause_req, 1'b1);
        check("busy_on", upl_busy, 1'b1);
        n = 0;
        while (ioctl_wait && n < 50) begin
            tick();
            n++;
        end
        check("ready_reached", ioctl_wait, 1'b0);
    endtask

    task automatic end_session();
        ioctl_upload = 1'b0;
        tick();
        check("fin_pause", pause_req, 1'b0);
        check("fin_busy", upl_busy, 1'b0);
        check("fin_wait", ioctl_wait, 1'b0);
        tick();
        in_sess = 1'b0;
        if (bytes_read >= DEPTH && !sess_we) exp_dirty = 1'b0;
        check("dirty_end", save_dirty, exp_dirty);
    endtask

    task automatic pulse_we();
        cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
        exp_dirty = 1'b1;
        if (in_sess) sess_we = 1'b1;
        check("dirty_set", save_dirty, exp_dirty);
    endtask

    initial begin
        int n, rd0, p0, w0;
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom);
        ram[0] = 8'h5A;
        ram[5] = 8'h33;
        reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_rd = 1'b0;
        ioctl_addr = '0; pause_ack = 1'b0; cpu_we = 1'b0;
        tick(); tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        pulse_we();

        // Strobe during PAUSE, late acknowledge, then the full image.
        ioctl_index = 8'd4; ioctl_upload = 1'b1; in_sess = 1'b1; sess_we = 1'b0; bytes_read = 0;
        tick();
        check("p_pause", pause_req, 1'b1);
        check("p_wait", ioctl_wait, 1'b1);
        rd0 = mem_rd_cnt;
        ioctl_addr = 25'd0; ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("p_wait_held", ioctl_wait, 1'b1);
            tick();
        end
        check("p_no_mrd", mem_rd_cnt - rd0, 0);
        pause_ack = 1'b1;
        tick();
        check("p_mrd", mem_rd, 1'b1);
        check("p_maddr", mem_addr, '0);
        n = 1;
        while (ioctl_wait && n < 20) begin
            tick();
            n++;
        end
        check("p_latency", n, RD_LAT + 2);
        check("p_din", ioctl_din, 8'h5A);
        bytes_read = 1;
        for (int a = 1; a < DEPTH; a++) do_read(25'(a));
        for (int i = 0; i < 4; i++) do_read(25'($urandom_range(0, DEPTH - 1)));
        check("dirty_before_end", save_dirty, 1'b1);
        end_session();

        // Out-of-range strobes do not count; 2047 good bytes leave it dirty.
        pulse_we();
        start_session();
        do_read(25'd3000);
        do_read(25'(DEPTH + 5));
        for (int i = 0; i < 3; i++) do_read(25'($urandom_range(DEPTH, 33554431)));
        for (int a = 0; a < DEPTH - 1; a++) do_read(25'(a));
        end_session();

        // Abort after 100 bytes, last one dropped mid-read.
        start_session();
        for (int i = 0; i < 99; i++) do_read(25'($urandom_range(0, DEPTH - 1)));
        ioctl_addr = 25'd5; ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0; ioctl_upload = 1'b0;
        n = 1;
        while (ioctl_wait && n < 20) begin
            tick();
            n++;
        end
        check("abort_latency", n, RD_LAT + 2);
        check("abort_din", ioctl_din, 8'h33);
        bytes_read++;
        end_session();

        // CPU write inside a complete upload keeps the flag set.
        start_session();
        for (int a = 0; a < DEPTH / 2; a++) do_read(25'(a));
        pulse_we();
        for (int a = DEPTH / 2; a < DEPTH; a++) do_read(25'(a));
        end_session();

        // Foreign index: block stays idle.
        rd0 = mem_rd_cnt; p0 = pause_cnt; w0 = wait_cnt;
        ioctl_index = 8'd0; ioctl_upload = 1'b1;
        for (int i = 0; i < 30; i++) begin
            ioctl_rd = 1'($urandom_range(0, 1));
            ioctl_addr = 25'($urandom_range(0, DEPTH - 1));
            tick();
        end
        ioctl_rd = 1'b0; ioctl_upload = 1'b0;
        tick();
        check("idx0_pause", pause_cnt - p0, 0);
        check("idx0_wait", wait_cnt - w0, 0);
        check("idx0_mrd", mem_rd_cnt - rd0, 0);

        // Reset while in LAT, then a clean restart.
        start_session();
        ioctl_addr = 25'd5; ioctl_rd = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        tick();
        check("lat_pause_pre", pause_req, 1'b1);
        reset = 1'b1; ioctl_upload = 1'b0;
        tick();
        check_all_zero("lat_reset");
        exp_dirty = 1'b0;
        reset = 1'b0;
        tick(); tick();
        start_session();
        do_read(25'($urandom_range(0, DEPTH - 1)));
        do_read(25'd0);
        end_session();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nvram_upload_ctl.md
Name: nvram_upload_ctl

Overview:
- Core-side responder for the HPS ioctl upload path, the read direction of the ioctl download port that loads ROMs.
- On an upload request for the save-RAM index, it pauses the CPU and serves `ioctl_rd` strobes from a RAM read port, throttling the HPS with `ioctl_wait`.
- It tracks a dirty flag so the OSD knows when save RAM has changed since the last full upload.
- It sits between hps_io and the game's battery/high-score RAM, in the `clk_sys` domain.

Parameters:
- AW, 11, RAM address width.
- DEPTH, 2048, bytes exposed for upload (≤ 2^AW).
- UPL_INDEX, 8'd4, `ioctl_index` value this block responds to.
- RD_LAT, 1, RAM read latency in cycles (1..3).
- FILL, 8'hFF, byte returned for addresses ≥ DEPTH.

Ports:
- clk_sys, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- ioctl_upload, input, 1: upload in progress (level, from hps_io).
- ioctl_index, input, 8: selected file index.
- ioctl_rd, input, 1: one-cycle read strobe.
- ioctl_addr, input, 25: byte address of the strobe.
- ioctl_din, output, 8: read data to hps_io.
- ioctl_wait, output, 1: stall request to hps_io.
- pause_req, output, 1: CPU pause request.
- pause_ack, input, 1: CPU halted.
- mem_addr, output, AW: RAM read address.
- mem_rd, output, 1: RAM read enable.
- mem_q, input, 8: RAM read data, valid RD_LAT cycles after `mem_rd`.
- cpu_we, input, 1: CPU write strobe to save RAM.
- save_dirty, output, 1: RAM modified since last complete upload.
- upl_busy, output, 1: upload session active.

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0, including `ioctl_din`=0 and `save_dirty`=0. Pending strobe, latency counter and byte counter cleared.
- `sel` = `ioctl_upload` && (`ioctl_index` == UPL_INDEX). A session starts on a rising edge of `sel`, sampled registered.
- FSM states: IDLE, PAUSE, READY, FETCH, LAT, FINISH.
- IDLE:
  - On a `sel` rise: `pause_req`=1, `upl_busy`=1, `ioctl_wait`=1, byte counter=0, go to PAUSE.
  - `ioctl_rd` strobes are ignored.
- PAUSE:
  - Hold `ioctl_wait`=1.
  - A strobe arriving here is latched as pending (address captured; one deep, a later strobe overwrites it).
  - On `pause_ack`=1: go to FETCH if a strobe is pending, else READY; `ioctl_wait`=0 if nothing is pending.
- READY:
  - `ioctl_wait`=0.
  - On `ioctl_rd`: `ioctl_wait` asserts combinationally in the same cycle and stays registered high afterwards; capture the address; go to FETCH.
- FETCH:
  - If addr < DEPTH: `mem_addr`=addr[AW-1:0], `mem_rd`=1 for exactly one cycle, go to LAT.
  - Otherwise: `ioctl_din`=FILL, no `mem_rd`, go to READY with `ioctl_wait`=0 the next cycle.
- LAT:
  - Count RD_LAT cycles, then register `ioctl_din`=mem_q and drop `ioctl_wait`.
  - Increment the byte counter (saturates at DEPTH). Go to READY.
- Read latency: strobe-to-wait-deassert is RD_LAT+2 cycles. `ioctl_din` is stable from `ioctl_wait` falling until the next strobe.
- Session end: a `sel` fall while in READY or PAUSE goes to FINISH. A fall while in FETCH or LAT completes the current read first, then goes to FINISH.
- FINISH (one cycle):
  - `pause_req`=0, `upl_busy`=0, `ioctl_wait`=0.
  - `save_dirty` is cleared only if the byte counter == DEPTH and no `cpu_we` occurred during the session.
  - Go to IDLE.
- `save_dirty` is set on any `cpu_we` outside the FINISH-clear cycle. A set and a clear in the same cycle resolve to set. A `cpu_we` during a session, which should be impossible while paused, marks the session dirty.
- Back-to-back strobes are legal; each is served in order, with no overlap because `ioctl_wait` is held.
- Address wrap: only addr[AW-1:0] drives `mem_addr`, and only after the DEPTH check, so no aliasing.

Decomposition:
- Package `nvram_pkg`:
  - typedef for the FSM state enum.
  - Default constants UPL_INDEX_DEF and FILL_DEF.
- One sub-module, `lat_pipe`: an RD_LAT-deep valid shift register that produces the data-valid strike for LAT.

Test Plan:
- Reset during LAT with `pause_req`=1 → next cycle all outputs 0 and state IDLE; a new `sel` rise restarts cleanly.
- Index 4, `pause_ack` after 5 cycles, strobe at addr 0 during PAUSE → `ioctl_wait` held until ack. `mem_rd` fires with `mem_addr`=0 after ack. `ioctl_din`=mem_q=0x5A and wait drops RD_LAT+2 cycles after entering FETCH.
- Read 0..2047 back-to-back with RD_LAT=2 → every byte matches the RAM model. On `ioctl_upload` falling, `save_dirty` goes 1→0 and `pause_req`=0.
- Strobe at addr 3000 → no `mem_rd`; `ioctl_din`=0xFF; byte counter unchanged.
- Abort after 100 bytes with `save_dirty`=1 → `pause_req` drops and `save_dirty` stays 1. Also: `cpu_we` during a full upload → `save_dirty` stays 1.
- `ioctl_index`=0 upload → no `pause_req`, no `mem_rd`, `ioctl_wait`=0 throughout.
